// File: rtl/mem_responder.sv
// mem_responder
// ---------------------------------------------------------------------------
// Word-addressed memory responder for the multicycle processor. The request
// side raises Req in IDLE. The RAM access is committed after WAIT_CYCLES wait
// states. Completion is a one-cycle Ack pulse.
//
// Handshake: Req/WE/Addr/WData are sampled only at an edge where the block
// is IDLE; while Busy is high Req is ignored and nothing is queued. Ack is
// high for exactly one cycle (the RESP state); RData is valid with Ack and
// held until the next read completes; Err is valid with Ack.
//
// Ports:
//   CLK    in   clock, rising edge
//   Reset  in   synchronous, active-high reset
//   Req    in   request strobe
//   WE     in   1 = write, 0 = read
//   Addr   in   byte address (word index = Addr[DEPTH_LOG2:1])
//   WData  in   write data
//   Ack    out  one-cycle completion pulse
//   RData  out  read data
//   Busy   out  high whenever the state is not IDLE
//   Err    out  misaligned-access flag (RESP only)
//
// Optional feature: define MEM_RESP_MISALIGN_ERR_EN to reject odd byte
// addresses. A rejected request does no RAM access and answers with Err=1.
// Without it, Addr[0] is ignored and Err stays 0.
//
// The FSM state is visible as state_q for bound checkers.
// ---------------------------------------------------------------------------
module mem_responder #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              Req,
    input  logic              WE,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] WData,
    output logic              Ack,
    output logic [DATA_W-1:0] RData,
    output logic              Busy,
    output logic              Err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;

    logic [DATA_W-1:0]   mem [0:(1<<DEPTH_LOG2)-1];

    // The access fields come from the live inputs when IDLE goes straight
    // to RESP (WAIT_CYCLES=0). Otherwise they come from the latched copies.
    logic                  acc_we;
    logic [ADDR_W-1:0]     acc_addr;
    logic [DATA_W-1:0]     acc_wdata;
    logic [DEPTH_LOG2-1:0] acc_idx;
    logic                  do_access;
    logic                  misaligned;
    logic                  mem_wr;
    logic                  unused_addr;

    assign acc_idx = acc_addr[DEPTH_LOG2:1];

`ifdef MEM_RESP_MISALIGN_ERR_EN
    assign misaligned = acc_addr[0];
`else
    assign misaligned = 1'b0;
`endif

    // Upper address bits are ignored so the address space wraps on the RAM.
    assign unused_addr = ^{acc_addr[ADDR_W-1:DEPTH_LOG2+1], acc_addr[0]};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        err_d     = 1'b0;
        do_access = 1'b0;
        acc_we    = we_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;

        case (state_q)
            S_IDLE: begin
                acc_we    = WE;
                acc_addr  = Addr;
                acc_wdata = WData;
                if (Req) begin
                    we_d    = WE;
                    addr_d  = Addr;
                    wdata_d = WData;
                    if (WAIT_CYCLES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                    end else begin
                        state_d   = S_RESP;
                        do_access = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d   = S_RESP;
                    do_access = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (do_access) begin
            err_d = misaligned;
        end

        mem_wr  = do_access && acc_we && !misaligned;
        rdata_d = rdata_q;
        if (do_access && !acc_we && !misaligned) begin
            rdata_d = mem[acc_idx];
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // RAM contents survive reset. Reset at the access edge drops the write.
    always_ff @(posedge CLK) begin
        if (!Reset && mem_wr) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

    assign Ack   = (state_q == S_RESP);
    assign Busy  = (state_q != S_IDLE);
    assign RData = rdata_q;
    assign Err   = err_q;

endmodule
